// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive path (and the future transmit path):
//   - rx_state_t : receiver FSM state encoding
//   - PARITY_ODD : parity sense used when the parity option is built in
//                  (0 = even parity)
//   - calc_div   : oversample-tick divider, rounded to the nearest integer
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    LOAD   = 3'd5
  } rx_state_t;

  localparam logic PARITY_ODD = 1'b0;

  // round(clk_hz / (baud * os)) using integer arithmetic only.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_os_tick_gen
// Free-running divider that produces a one-clock os_tick every DIV clocks.
// A restart pulse zeroes the divider, so the first tick after a restart
// arrives exactly DIV clocks later (phase-aligns sampling to the start edge).
// Ports:
//   CLOCK_50  in  system clock
//   reset_n   in  synchronous active-low reset
//   restart   in  synchronous divider restart
//   os_tick   out one-cycle pulse every DIV clocks
// ---------------------------------------------------------------------------
module uart_os_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic restart,
  output logic os_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || restart) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign os_tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver. Synchronises the asynchronous UART_RXD pin,
// oversamples it, samples each bit at mid-bit (LSB first), checks the stop
// bit and hands the word to the consumer through a one-entry holding
// register with a valid/ready handshake.
//
// Build option: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (sense set by uart_pkg::PARITY_ODD). Without
// it the PARITY state is never entered and parity_err is tied to 0.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset_n     in   synchronous active-low reset (aborts any frame)
//   UART_RXD    in   asynchronous serial input, idle high
//   rx_data     out  received word, stable while rx_valid=1
//   rx_valid    out  holding register full
//   rx_ready    in   consumer accepts; transfer on rx_valid & rx_ready
//   frame_err   out  stop bit was 0 for the word in rx_data
//   parity_err  out  parity mismatch for the word in rx_data
//   overrun     out  one-cycle pulse: frame completed while holding reg full
//   busy        out  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 UART_RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_prev;
  logic                 start_edge;
  logic                 os_tick;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
`endif

  // Two-flop synchroniser; reset to the idle-line level so that leaving
  // reset never looks like a start edge.
  // NOTE: non-blocking assignments give every flop the pre-edge value of
  // its neighbour, which is what makes this a two-stage pipeline.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], UART_RXD};
      rxd_prev <= sync_q[1];
    end
  end

  assign rxd_s = sync_q[1];

  // Falling edge only: a line held low after a framing error (break)
  // never produces a second start.
  assign start_edge = (state == IDLE) && rxd_prev && !rxd_s;

  uart_os_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .restart  (start_edge),
    .os_tick  (os_tick)
  );

  // Receiver FSM with registered outputs.
  // NOTE: the data path (shift register, holding register) is reset along
  // with the control state so every output is a known 0 after reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      // Consumer takes the word; a LOAD in the same cycle overrides below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (os_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rxd_s) begin
                // Line high at mid start bit: glitch, drop silently.
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              // LSB arrives first, so shift in at the MSB end.
              shift_q  <= {rxd_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (os_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              perr_q   <= ((^shift_q) ^ rxd_s) != PARITY_ODD;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        STOP: begin
          if (os_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              ferr_q   <= !rxd_s;
              state    <= LOAD;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!rx_valid || rx_ready) begin
            rx_data   <= shift_q;
            frame_err <= ferr_q;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_q;
`endif
            rx_valid  <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Drives serial frames onto UART_RXD, pushes the expected word for every
// frame that should be delivered into a queue, and a monitor pops and
// compares on each rx_valid & rx_ready transfer. Overrun pulses are counted
// against the number of frames deliberately dropped.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int BIT = 160;  // clocks per bit: DIV 10 x OVERSAMPLE 16

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       UART_RXD = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int errors   = 0;
  int ovr_seen = 0;
  int ovr_exp  = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_param #(
    .CLK_FREQ   (1600000),
    .BAUD       (10000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .UART_RXD   (UART_RXD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference parity rule: even parity over data plus parity bit.
  function automatic logic exp_perr(input logic [7:0] d, input logic pbit);
`ifdef UART_RX_PARITY_EN
    return ((^d) ^ pbit) != 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge CLOCK_50) begin
    if (reset_n) begin
      if (overrun) ovr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data %0h, no word expected", rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data",       32'(rx_data),    32'(mon_e.data));
          check("word_frame_err",  32'(frame_err),  32'(mon_e.ferr));
          check("word_parity_err", 32'(parity_err), 32'(mon_e.perr));
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pbit,
                            input bit expect_word, input bit hold_low);
    exp_t e;
    if (expect_word) begin
      e.data = d;
      e.ferr = !stop_bit;
      e.perr = exp_perr(d, pbit);
      exp_q.push_back(e);
    end
    UART_RXD = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = d[i];
      wait_clks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    UART_RXD = pbit;
    wait_clks(BIT);
`endif
    UART_RXD = stop_bit;
    wait_clks(BIT);
    if (!hold_low) UART_RXD = 1'b1;
  endtask

  // Bounded wait for every expected word to be consumed.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * BIT; i++) begin
      if (exp_q.size() == 0) break;
      wait_clks(1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    logic       pb;

    // Reset state
    wait_clks(3);
    check("rst_rx_data",    32'(rx_data),    32'h0);
    check("rst_rx_valid",   32'(rx_valid),   32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    reset_n = 1'b1;
    wait_clks(20);

    // 1. Clean frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain("t1_drain");
    check("t1_valid_low", 32'(rx_valid), 32'h0);
    wait_clks(40);

    // 2. Glitch shorter than half a bit
    UART_RXD = 1'b0;
    wait_clks(20);
    check("t2_busy_during", 32'(busy), 32'h1);
    wait_clks(40);
    UART_RXD = 1'b1;
    wait_clks(100);
    check("t2_busy_after", 32'(busy),     32'h0);
    check("t2_no_valid",   32'(rx_valid), 32'h0);

    // 3. Framing error, then line held low (break)
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("t3_drain");
    wait_clks(3 * BIT);
    check("t3_break_idle", 32'(busy), 32'h0);
    UART_RXD = 1'b1;
    wait_clks(40);
    check("t3_no_second", 32'(rx_valid), 32'h0);

    // 4. Overrun: second word dropped while first is held
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    ovr_exp++;
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_clks(10);
    check("t4_held_data",  32'(rx_data),  32'h11);
    check("t4_held_valid", 32'(rx_valid), 32'h1);
    check("t4_overrun",    32'(ovr_seen), 32'(ovr_exp));
    rx_ready = 1'b1;
    wait_drain("t4_drain");
    wait_clks(2);
    check("t4_valid_low", 32'(rx_valid), 32'h0);
    wait_clks(30);

    // Randomised frames against the reference model
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      pb = 1'($urandom_range(0, 1));
      send_frame(d, sb, pb, 1'b1, 1'b0);
      wait_clks($urandom_range(2, 40));
    end
    wait_drain("rand_drain");

    // 5. Reset during data bit 4 of 0xFF
    UART_RXD = 1'b0;
    wait_clks(BIT);
    UART_RXD = 1'b1;
    wait_clks(4 * BIT + BIT / 2);
    check("t5_busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    wait_clks(1);
    check("t5_rx_data",    32'(rx_data),    32'h0);
    check("t5_rx_valid",   32'(rx_valid),   32'h0);
    check("t5_frame_err",  32'(frame_err),  32'h0);
    check("t5_parity_err", 32'(parity_err), 32'h0);
    check("t5_overrun",    32'(overrun),    32'h0);
    check("t5_busy",       32'(busy),       32'h0);
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(BIT);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain("t5_drain");
    wait_clks(30);

`ifdef UART_RX_PARITY_EN
    // 6. Parity: 0x07 has odd weight, so parity bit 0 is a mismatch
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain("t6_perr_drain");
    check("t6_perr_set", 32'(parity_err), 32'h1);
    wait_clks(30);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain("t6_ok_drain");
    check("t6_perr_clear", 32'(parity_err), 32'h0);
    wait_clks(30);
`endif

    check("final_overruns", 32'(ovr_seen), 32'(ovr_exp));
    check("final_queue",    32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
